// File: rtl/xbar_cfg_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | xbar_cfg_sequencer: replays stored crossbar contexts cyclically         |
// | Revision: 1.0                                                           |
// +-----------------------------------------------------------------------+
module xbar_cfg_sequencer #(
  parameter int NUM_CTX = 16,
  parameter int CTX_W   = $clog2(NUM_CTX),
  parameter int ITER_W  = 16,
  parameter int NUM_IN  = 6,
  parameter int NUM_OUT = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i__cfg_wr_en,
  input  logic [CTX_W-1:0]            i__cfg_wr_addr,
  input  logic [NUM_IN*NUM_OUT+3:0]   i__cfg_wr_data,
  input  logic [CTX_W:0]              i__ii,
  input  logic [ITER_W-1:0]           i__num_iter,
  input  logic                        i__start,
  input  logic                        i__stop,
  input  logic                        i__stall,
  output logic [NUM_IN-1:0]           o__sel [NUM_OUT-1:0],
  output logic [3:0]                  o__regbypass,
  output logic [CTX_W-1:0]            o__ctx_idx,
  output logic                        o__busy,
  output logic                        o__done,
  output logic                        o__err
);

  localparam int                c_data_w   = NUM_IN*NUM_OUT + 4;
  localparam logic [CTX_W:0]    c_max_ii   = (CTX_W+1)'(NUM_CTX);
  localparam logic [CTX_W:0]    c_ii_one   = (CTX_W+1)'(1);
  localparam logic [CTX_W-1:0]  c_ctx_one  = CTX_W'(1);
  localparam logic [ITER_W-1:0] c_iter_one = ITER_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_data_w-1:0]   r_mem [NUM_CTX];
  logic [CTX_W:0]        r_ii;
  logic [ITER_W-1:0]     r_num_iter;
  logic [ITER_W-1:0]     r_iter_cnt;
  logic [CTX_W-1:0]      r_ctx;
  logic [NUM_IN-1:0]     r_sel [NUM_OUT-1:0];
  logic [3:0]            r_regbypass;
  logic                  r_done;
  logic                  r_err;

  logic                  w_sel_ok;
  logic                  w_wr_ok;
  logic                  w_ii_ok;
  logic                  w_last;
  logic                  w_final;
  logic [CTX_W-1:0]      w_next_ctx;
  logic [c_data_w-1:0]   w_load_data;

  // A select field may be all-zero (output idle) or one-hot, never multi-hot.
  always_comb begin
    w_sel_ok = 1'b1;
    for (int k = 0; k < NUM_OUT; k++) begin
      if ($countones(i__cfg_wr_data[NUM_IN*k +: NUM_IN]) > 1) w_sel_ok = 1'b0;
    end
  end

  always_comb begin
    w_wr_ok    = i__cfg_wr_en && (r_state == S_IDLE) && w_sel_ok;
    w_ii_ok    = (i__ii != '0) && (i__ii <= c_max_ii);
    w_last     = ({1'b0, r_ctx} == (r_ii - c_ii_one));
    w_final    = w_last && (r_num_iter != '0) && (r_iter_cnt == (r_num_iter - c_iter_one));
    w_next_ctx = w_last ? '0 : (r_ctx + c_ctx_one);
    // On start, forward a same-cycle write to context 0 so it is seen first.
    if (r_state == S_IDLE)
      w_load_data = (w_wr_ok && (i__cfg_wr_addr == '0)) ? i__cfg_wr_data : r_mem[0];
    else
      w_load_data = r_mem[w_next_ctx];
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[i__cfg_wr_addr] <= i__cfg_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ii        <= '0;
      r_num_iter  <= '0;
      r_iter_cnt  <= '0;
      r_ctx       <= '0;
      r_regbypass <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      for (int k = 0; k < NUM_OUT; k++) r_sel[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i__cfg_wr_en && !w_sel_ok) r_err <= 1'b1;
          if (i__start) begin
            if (w_ii_ok) begin
              r_state     <= S_RUN;
              r_err       <= 1'b0;
              r_ii        <= i__ii;
              r_num_iter  <= i__num_iter;
              r_iter_cnt  <= '0;
              r_ctx       <= '0;
              r_regbypass <= w_load_data[c_data_w-1 -: 4];
              for (int k = 0; k < NUM_OUT; k++) r_sel[k] <= w_load_data[NUM_IN*k +: NUM_IN];
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i__cfg_wr_en) r_err <= 1'b1;
          if (i__stop) begin
            r_state     <= S_IDLE;
            r_ctx       <= '0;
            r_regbypass <= '0;
            for (int k = 0; k < NUM_OUT; k++) r_sel[k] <= '0;
          end else if (!i__stall) begin
            if (w_last) r_iter_cnt <= r_iter_cnt + c_iter_one;
            if (w_final) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_regbypass <= '0;
              for (int k = 0; k < NUM_OUT; k++) r_sel[k] <= '0;
            end else begin
              r_ctx       <= w_next_ctx;
              r_regbypass <= w_load_data[c_data_w-1 -: 4];
              for (int k = 0; k < NUM_OUT; k++) r_sel[k] <= w_load_data[NUM_IN*k +: NUM_IN];
            end
          end
        end
        S_DONE: begin
          if (i__cfg_wr_en) r_err <= 1'b1;
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ctx   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o__sel       = r_sel;
  assign o__regbypass = r_regbypass;
  assign o__ctx_idx   = r_ctx;
  assign o__busy      = (r_state == S_RUN);
  assign o__done      = r_done;
  assign o__err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xbar_cfg_sequencer.sv
`default_nettype none
// Directed bench for xbar_cfg_sequencer with immediate-assertion checks.
module tb_xbar_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_wr_en;
  logic [3:0]  cfg_wr_addr;
  logic [45:0] cfg_wr_data;
  logic [4:0]  ii;
  logic [15:0] num_iter;
  logic        start, stop, stall;
  logic [5:0]  sel [6:0];
  logic [3:0]  regbypass;
  logic [3:0]  ctx_idx;
  logic        busy, done, err;

  int checks = 0;
  int failures = 0;

  xbar_cfg_sequencer dut (
    .clk(clk), .reset(reset),
    .i__cfg_wr_en(cfg_wr_en), .i__cfg_wr_addr(cfg_wr_addr), .i__cfg_wr_data(cfg_wr_data),
    .i__ii(ii), .i__num_iter(num_iter), .i__start(start), .i__stop(stop), .i__stall(stall),
    .o__sel(sel), .o__regbypass(regbypass), .o__ctx_idx(ctx_idx),
    .o__busy(busy), .o__done(done), .o__err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [45:0] mkd(input int k, input logic [5:0] s, input logic [3:0] rb);
    logic [45:0] d;
    d = '0;
    d[6*k +: 6] = s;
    d[45:42] = rb;
    return d;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [45:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick;
    cfg_wr_en = 1'b0;
  endtask

  task automatic go(input logic [4:0] n_ii, input logic [15:0] n_it);
    ii = n_ii; num_iter = n_it; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 7; k++) chk(tag, {26'd0, sel[k]}, 32'd0);
    chk(tag, {28'd0, regbypass}, 32'd0);
    chk(tag, {28'd0, ctx_idx}, 32'd0);
    chk(tag, {31'd0, busy}, 32'd0);
    chk(tag, {31'd0, done}, 32'd0);
  endtask

  logic [3:0] exp_ctx [9];

  initial begin
    reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    ii = '0; num_iter = '0; start = 1'b0; stop = 1'b0; stall = 1'b0;
    #2;
    chk_zero("reset_outputs");
    chk("reset_err", {31'd0, err}, 32'd0);
    tick; tick;
    reset = 1'b0;
    tick;

    // Basic run: ii=2, num_iter=3
    wr(4'd0, mkd(0, 6'b000001, 4'b0001));
    wr(4'd1, mkd(0, 6'b000100, 4'b0000));
    wr(4'd2, mkd(3, 6'b000001, 4'b0010));
    go(5'd2, 16'd3);
    chk("run_rb0", {28'd0, regbypass}, 32'h1);
    for (int c = 1; c <= 6; c++) begin
      chk("run_ctx", {28'd0, ctx_idx}, (c % 2 == 1) ? 32'd0 : 32'd1);
      chk("run_sel0", {26'd0, sel[0]}, (c % 2 == 1) ? 32'h01 : 32'h04);
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_done_low", {31'd0, done}, 32'd0);
      tick;
    end
    chk("run_done", {31'd0, done}, 32'd1);
    chk("run_busy_off", {31'd0, busy}, 32'd0);
    chk("run_sel_off", {26'd0, sel[0]}, 32'd0);
    chk("run_rb_off", {28'd0, regbypass}, 32'd0);
    tick;
    chk("run_done_pulse", {31'd0, done}, 32'd0);

    // Stall three cycles while ctx=1
    exp_ctx = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
    go(5'd2, 16'd3);
    for (int i = 0; i < 9; i++) begin
      chk("stall_ctx", {28'd0, ctx_idx}, {28'd0, exp_ctx[i]});
      chk("stall_done_low", {31'd0, done}, 32'd0);
      stall = (i >= 1 && i <= 3);
      tick;
    end
    stall = 1'b0;
    chk("stall_done", {31'd0, done}, 32'd1);
    tick;

    // Multi-hot write rejected, ctx2 retains prior value
    wr(4'd2, mkd(3, 6'b000011, 4'b0000));
    chk("badwr_err", {31'd0, err}, 32'd1);
    go(5'd3, 16'd1);
    chk("badwr_err_clr", {31'd0, err}, 32'd0);
    tick; tick;
    chk("badwr_ctx2", {28'd0, ctx_idx}, 32'd2);
    chk("badwr_sel3", {26'd0, sel[3]}, 32'h01);
    chk("badwr_rb", {28'd0, regbypass}, 32'h2);
    tick;
    chk("badwr_done", {31'd0, done}, 32'd1);
    tick;

    // Illegal ii values
    go(5'd0, 16'd1);
    chk("ii0_busy", {31'd0, busy}, 32'd0);
    chk("ii0_err", {31'd0, err}, 32'd1);
    go(5'd17, 16'd1);
    chk("ii17_busy", {31'd0, busy}, 32'd0);
    chk("ii17_err", {31'd0, err}, 32'd1);

    // Full-depth loop
    go(5'd16, 16'd1);
    chk("ii16_err_clr", {31'd0, err}, 32'd0);
    for (int c = 0; c < 16; c++) begin
      chk("ii16_ctx", {28'd0, ctx_idx}, c);
      chk("ii16_busy", {31'd0, busy}, 32'd1);
      tick;
    end
    chk("ii16_done", {31'd0, done}, 32'd1);
    tick;

    // Run forever with ii=1, write during run, then stop
    go(5'd1, 16'd0);
    for (int c = 0; c < 100; c++) begin
      chk("inf_ctx", {28'd0, ctx_idx}, 32'd0);
      chk("inf_busy", {31'd0, busy}, 32'd1);
      if (c == 50) begin
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0; cfg_wr_data = mkd(0, 6'b100000, 4'b1111);
      end else begin
        cfg_wr_en = 1'b0;
      end
      tick;
      if (c == 50) chk("inf_wr_err", {31'd0, err}, 32'd1);
    end
    cfg_wr_en = 1'b0;
    stop = 1'b1;
    stall = 1'b1;
    tick;
    stop = 1'b0;
    stall = 1'b0;
    chk_zero("stop_outputs");
    tick;
    chk("stop_no_done", {31'd0, done}, 32'd0);
    go(5'd1, 16'd1);
    chk("ignored_wr_sel0", {26'd0, sel[0]}, 32'h01);
    chk("ignored_wr_rb", {28'd0, regbypass}, 32'h1);
    tick;
    chk("ii1_done", {31'd0, done}, 32'd1);
    tick;

    // Asynchronous reset mid-run
    go(5'd2, 16'd3);
    tick;
    chk("arst_pre_ctx", {28'd0, ctx_idx}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_zero("arst_outputs");
    tick;
    reset = 1'b0;
    tick;
    chk("arst_idle", {31'd0, busy}, 32'd0);
    wr(4'd0, mkd(0, 6'b000001, 4'b0001));
    wr(4'd1, mkd(0, 6'b000100, 4'b0000));
    go(5'd2, 16'd1);
    chk("arst_run_ctx0", {28'd0, ctx_idx}, 32'd0);
    chk("arst_run_sel0", {26'd0, sel[0]}, 32'h01);
    tick;
    chk("arst_run_ctx1", {28'd0, ctx_idx}, 32'd1);
    chk("arst_run_sel1", {26'd0, sel[0]}, 32'h04);
    tick;
    chk("arst_run_done", {31'd0, done}, 32'd1);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xbar_cfg_sequencer.md
Name: xbar_cfg_sequencer

Overview:
- Per-tile context sequencer that drives the select and register-bypass controls of the 7-output x 6-input bypass crossbar.
- Holds up to NUM_CTX crossbar configurations, loaded through a write port while idle.
- When started, replays contexts 0..ii-1 cyclically, one context per non-stalled cycle, for a programmed number of iterations, then signals done.
- Sits between the tile configuration bus and the crossbar; its o__sel and o__regbypass outputs connect directly to the crossbar's i__sel and regbypass inputs.

Parameters:
- NUM_CTX, 16, number of stored contexts (power of 2, >=2).
- CTX_W, $clog2(NUM_CTX), context address width.
- ITER_W, 16, width of the iteration count.
- NUM_IN, 6, crossbar inputs (one-hot select width); fixed.
- NUM_OUT, 7, crossbar outputs; fixed.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i__cfg_wr_en  input  1  context write strobe.
- i__cfg_wr_addr  input  CTX_W  context index to write.
- i__cfg_wr_data  input  46  packed context: bits [6k+5:6k] = one-hot select for output k (k=0..6); bits [45:42] = regbypass.
- i__ii  input  CTX_W+1  loop length in contexts (1..NUM_CTX); sampled on start.
- i__num_iter  input  ITER_W  iterations to run; 0 = run forever; sampled on start.
- i__start  input  1  start pulse.
- i__stop  input  1  abort pulse.
- i__stall  input  1  hold the current context.
- o__sel  output  NUM_IN x NUM_OUT  unpacked array [NUM_OUT-1:0] of 6-bit one-hot selects.
- o__regbypass  output  4  regbypass vector to the crossbar.
- o__ctx_idx  output  CTX_W  context currently driven.
- o__busy  output  1  high in the RUN state.
- o__done  output  1  one-cycle pulse when the final iteration completes.
- o__err  output  1  sticky configuration error flag.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including every o__sel entry, o__ctx_idx, o__busy, o__done and o__err.
  - Context storage contents are don't-care.
- States: IDLE, RUN, DONE.
- Writes:
  - A write is accepted only in IDLE. Accepted data is visible to a start issued in the next cycle.
  - A write whose select field has more than one bit set is rejected (storage unchanged) and sets o__err.
  - An all-zero select field is legal and means "output k idle".
  - A write in RUN or DONE is ignored and sets o__err.
- IDLE -> RUN:
  - Taken on i__start when 1 <= i__ii <= NUM_CTX; start also clears o__err.
  - If i__ii is 0 or greater than NUM_CTX, stay in IDLE and set o__err.
  - If i__start and i__cfg_wr_en arrive in the same cycle, the write is applied first and start is honoured.
- RUN:
  - Outputs are registered. Context 0 appears on o__sel, o__regbypass and o__ctx_idx in the cycle after start is sampled (latency 1).
  - Each cycle with i__stall=0 advances ctx; ctx wraps from ii-1 to 0.
  - The iteration counter increments on each wrap. With ii=1, every non-stalled cycle is a wrap.
  - While i__stall=1, all outputs and counters hold.
- RUN -> DONE:
  - Taken on the non-stalled wrap that completes iteration num_iter, when num_iter != 0.
  - In that cycle ctx is not reloaded. In the next cycle o__done=1 for exactly one cycle, o__busy=0, and o__sel/o__regbypass are 0.
- DONE -> IDLE: unconditional after one cycle.
- Stop:
  - i__stop in RUN moves to IDLE next cycle with all outputs zeroed and no o__done.
  - i__stop has priority over stall and over a same-cycle wrap/completion.
  - i__stop in IDLE or DONE has no effect.
- Start in RUN or DONE is ignored; it does not set o__err.
- Reset asserted mid-run: immediate return to IDLE with zeroed outputs. Storage is not required to survive reset.
- o__busy = (state == RUN).
- The iteration counter is ITER_W bits. num_iter = 2^ITER_W-1 must terminate correctly without overflow.

Test Plan:
- Program ctx0: o__sel[0]=6'b000001, regbypass=4'b0001; ctx1: o__sel[0]=6'b000100, regbypass=4'b0000. Start with ii=2, num_iter=3 -> o__ctx_idx = 0,1,0,1,0,1 on 6 consecutive cycles starting 1 cycle after start; o__sel[0] alternates accordingly; o__done pulses on cycle 7; o__busy low from cycle 7.
- Same setup with i__stall high for 3 cycles while ctx=1 -> ctx=1 held for 4 cycles total; o__done delayed by exactly 3 cycles.
- Write ctx2 with o__sel[3]=6'b000011 -> o__err=1 and ctx2 retains its prior value (verified by a run with ii=3); the next start clears o__err.
- Start with ii=0 -> stays IDLE, o__busy=0, o__err=1. Start with ii=NUM_CTX and num_iter=1 -> ctx steps 0..15, then o__done.
- num_iter=0, ii=1 -> o__ctx_idx stays 0 and o__busy stays high for 100 cycles. A write during the run sets o__err and is ignored. i__stop -> IDLE next cycle, outputs 0, no o__done.
- Assert reset mid-run at ctx=1 -> all outputs 0 in the same cycle (asynchronous). After deassertion, state is IDLE and a fresh program-and-start sequence works normally.
